pal_cfg_loader: RTL and testbench
=================================

Name: pal_cfg_loader

Overview:
Configuration sequencer for the PAL fabric. It accepts a configuration bitstream as bytes over a valid/ready handshake and serialises it LSB-first onto the PAL's single-bit cfg chain, one paced shift strobe per bit. After exactly CFG_BITS bits it issues an apply pulse and reports done. It sits between the host-facing pin logic and the PAL instance in the top wrapper, replacing manual bit-banging of the cfg, clock and enable pins.

Parameters:
NUM_INPUTS, 8, PAL input count N
NUM_INTERMEDIATE_STAGES, 18, PAL product terms P
NUM_OUTPUTS, 6, PAL output count M
CFG_BITS, 2*NUM_INPUTS*NUM_INTERMEDIATE_STAGES + NUM_INTERMEDIATE_STAGES*NUM_OUTPUTS (=396), chain length
SHIFT_DIV, 2, clk cycles per shifted bit; must be >= 1

Ports:
clk  in  1  system clock, all logic on rising edge
res_n  in  1  asynchronous active-low reset
start  in  1  level-sampled; begins a load when in IDLE or DONE
abort  in  1  returns FSM to IDLE from any state; no apply issued
byte_data  in  8  config byte, bit 0 shifted first
byte_valid  in  1  byte_data valid
byte_ready  out  1  loader accepts byte this cycle (valid & ready = transfer)
cfg_data  out  1  serial bit to PAL cfg input
cfg_shift  out  1  one-cycle strobe; PAL shifts cfg_data when high
cfg_apply  out  1  one-cycle pulse after last bit; drives PAL en
busy  out  1  high in LOAD, SHIFT, APPLY
done  out  1  high in DONE
bit_count  out  $clog2(CFG_BITS+1)  bits shifted so far in current load

Behaviour:
- Reset values: byte_ready=0, cfg_data=0, cfg_shift=0, cfg_apply=0, busy=0, done=0, bit_count=0; state IDLE.
- States: IDLE, LOAD, SHIFT, APPLY, DONE.
- IDLE/DONE: start=1 -> LOAD next cycle; bit_count cleared to 0; done cleared.
- LOAD: byte_ready=1. On valid&ready, latch byte into 8-bit shift register, set bits_in_byte = min(8, CFG_BITS - bit_count), go SHIFT. byte_ready is 0 in every other state.
- SHIFT: divider counts 0..SHIFT_DIV-1. At divider==0, cfg_data is updated to shreg[0]. At divider==SHIFT_DIV-1, cfg_shift=1 for one cycle, shreg shifts right, bit_count increments, bits_in_byte decrements. cfg_data therefore has at least one cycle of setup before the strobe, and cfg_data holds its value through the strobe.
- After the strobe of the last bit of the byte: if bit_count==CFG_BITS go APPLY, else go LOAD.
- Final byte: unused high bits (CFG_BITS mod 8) are discarded and never shifted.
- APPLY: cfg_apply=1 for exactly one cycle, then DONE.
- DONE: done=1 and held until start or abort. Extra bytes offered in DONE or IDLE are not accepted (byte_ready=0).
- abort has priority over every other transition. It drops to IDLE on the next edge, clears the divider and shreg, and clears cfg_shift and cfg_apply. bit_count holds its value for debug until the next start.
- start asserted while busy: ignored.
- Reset mid-operation: immediate return to reset values; the PAL keeps a partial chain and has not been applied.
- Latency for SHIFT_DIV=d, zero host stall: each byte costs 1 LOAD cycle + 8*d SHIFT cycles; apply follows the last strobe by 1 cycle.

Optional Feature:
Macro PAL_CFG_CRC_EN.
- Defined: a CRC-8 (poly 0x07, init 0x00) is computed over every shifted bit, MSB-first into the CRC register in shift order. After the last config bit, the FSM enters CHECK with byte_ready=1 and accepts one CRC byte.
  - Match -> APPLY.
  - Mismatch -> DONE with no apply, and output crc_err=1 held until the next start.
- Undefined: no CHECK state and no crc_err port; the FSM goes directly SHIFT->APPLY.

Test Plan:
1. SHIFT_DIV=2, CFG_BITS=396, stream 50 bytes of 0xA5 -> 396 cfg_shift strobes; cfg_data at strobes follows 1,0,1,0,0,1,0,1 repeating; last byte contributes 4 bits; one cfg_apply pulse; done=1; bit_count=396.
2. Host stalls byte_valid low for 10 cycles between bytes -> no cfg_shift while in LOAD; the bit sequence is identical to scenario 1.
3. abort asserted after 100 strobes -> IDLE next cycle, no cfg_apply, bit_count=100. A new start reloads cleanly from bit_count=0.
4. res_n pulsed low mid-byte (during SHIFT) -> all outputs go to reset values asynchronously; no apply.
5. start pulsed while busy, and bytes offered in DONE -> both ignored; byte_ready stays 0; no extra strobes.
6. With PAL_CFG_CRC_EN, send the correct CRC -> apply and done. Send CRC^0x01 -> no apply, done=1, crc_err=1.

Source files
------------

// File: rtl/pal_cfg_loader_if.sv
// Byte-stream handshake between the host-side pin logic and the PAL
// configuration loader.
//   byte_data  : configuration byte, bit 0 is shifted into the chain first
//   byte_valid : byte_data is valid
//   byte_ready : loader takes the byte this cycle (valid & ready = transfer)
// Modports: master = byte source (host side), slave = loader.
interface pal_cfg_loader_if;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       byte_ready;

  modport master (output byte_data, output byte_valid, input byte_ready);
  modport slave  (input byte_data, input byte_valid, output byte_ready);
endinterface

// File: rtl/pal_cfg_loader.sv
// Configuration sequencer for the PAL fabric. It takes the configuration
// bitstream as bytes and serialises it LSB-first onto the PAL's one-bit cfg
// chain. It drives one paced shift strobe per bit. After CFG_BITS bits it
// pulses cfg_apply (PAL enable) and reports done.
//
// Ports:
//   clk, res_n  : clock (rising edge), asynchronous active-low reset
//   start       : level-sampled, begins a load from IDLE or DONE
//   abort       : returns to IDLE from any state, no apply is issued
//   byte_if     : byte stream (slave side of pal_cfg_loader_if)
//   cfg_data    : serial bit to the PAL cfg input
//   cfg_shift   : one-cycle strobe, the PAL shifts cfg_data when high
//   cfg_apply   : one-cycle pulse after the last bit, drives PAL en
//   busy        : high in LOAD, SHIFT, CHECK and APPLY
//   done        : high in DONE
//   bit_count   : bits shifted so far in the current load
//   crc_err     : (PAL_CFG_CRC_EN only) CRC byte mismatch, held until start
//
// Build option: define PAL_CFG_CRC_EN to add a CRC-8 check (poly 0x07, init 0)
// over the shifted bits. The host sends one CRC byte after the last config
// bit. The chain is applied only if that byte matches the computed CRC.
module pal_cfg_loader #(
  parameter int NUM_INPUTS              = 8,
  parameter int NUM_INTERMEDIATE_STAGES = 18,
  parameter int NUM_OUTPUTS             = 6,
  parameter int CFG_BITS  = 2*NUM_INPUTS*NUM_INTERMEDIATE_STAGES
                            + NUM_INTERMEDIATE_STAGES*NUM_OUTPUTS,
  parameter int SHIFT_DIV = 2,
  localparam int CNT_W    = $clog2(CFG_BITS+1)
) (
  input  logic              clk,
  input  logic              res_n,
  input  logic              start,
  input  logic              abort,
  pal_cfg_loader_if.slave   byte_if,
  output logic              cfg_data,
  output logic              cfg_shift,
  output logic              cfg_apply,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  bit_count
`ifdef PAL_CFG_CRC_EN
  ,
  output logic              crc_err
`endif
);

  localparam int               DIV_W    = (SHIFT_DIV > 1) ? $clog2(SHIFT_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SHIFT_DIV - 1);
  localparam logic [CNT_W-1:0] CFG_LAST = CNT_W'(CFG_BITS - 1);
  localparam logic [CNT_W-1:0] CFG_ALL  = CNT_W'(CFG_BITS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_APPLY,
    S_DONE
`ifdef PAL_CFG_CRC_EN
    , S_CHECK
`endif
  } state_t;

  state_t           state, state_nxt;
  logic [DIV_W-1:0] div;
  logic [7:0]       shreg;
  logic [3:0]       bits_in_byte;
  logic [3:0]       first_cnt;
  logic [CNT_W-1:0] remaining;
  logic             ready;

`ifdef PAL_CFG_CRC_EN
  logic [7:0] crc;

  // CRC-8, poly x^8+x^2+x+1, one bit per step, MSB-first.
  function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic b);
    logic fb;
    fb = c[7] ^ b;
    return {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
  endfunction
`endif

  assign byte_if.byte_ready = ready;

  // The final byte may carry fewer than 8 useful bits. Its high bits are dropped.
  assign remaining = CFG_ALL - bit_count;
  assign first_cnt = (remaining >= CNT_W'(8)) ? 4'd8 : remaining[3:0];

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    cfg_shift = 1'b0;
    cfg_apply = 1'b0;
    case (state)
      S_IDLE, S_DONE: if (start) state_nxt = S_LOAD;
      S_LOAD: begin
        ready = 1'b1;
        if (byte_if.byte_valid) state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        if (div == DIV_LAST) begin
          cfg_shift = 1'b1;
          if (bits_in_byte == 4'd1) begin
`ifdef PAL_CFG_CRC_EN
            state_nxt = (bit_count == CFG_LAST) ? S_CHECK : S_LOAD;
`else
            state_nxt = (bit_count == CFG_LAST) ? S_APPLY : S_LOAD;
`endif
          end
        end
      end
`ifdef PAL_CFG_CRC_EN
      S_CHECK: begin
        ready = 1'b1;
        if (byte_if.byte_valid)
          state_nxt = (byte_if.byte_data == crc) ? S_APPLY : S_DONE;
      end
`endif
      S_APPLY: begin
        cfg_apply = 1'b1;
        state_nxt = S_DONE;
      end
      default: state_nxt = S_IDLE;
    endcase
    // abort wins over everything. It also suppresses the shift, handshake
    // and apply of this cycle, so the PAL never sees a half-taken step.
    if (abort) begin
      state_nxt = S_IDLE;
      ready     = 1'b0;
      cfg_shift = 1'b0;
      cfg_apply = 1'b0;
    end
  end

  assign busy = (state != S_IDLE) && (state != S_DONE);
  assign done = (state == S_DONE);

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state        <= S_IDLE;
      div          <= '0;
      shreg        <= '0;
      bits_in_byte <= '0;
      bit_count    <= '0;
      cfg_data     <= 1'b0;
`ifdef PAL_CFG_CRC_EN
      crc          <= '0;
      crc_err      <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (abort) begin
        // bit_count is left alone so the abort point stays visible.
        div          <= '0;
        shreg        <= '0;
        bits_in_byte <= '0;
      end else begin
        case (state)
          S_IDLE, S_DONE: begin
            if (start) begin
              bit_count <= '0;
`ifdef PAL_CFG_CRC_EN
              crc       <= '0;
              crc_err   <= 1'b0;
`endif
            end
          end
          S_LOAD: begin
            if (byte_if.byte_valid) begin
              shreg        <= byte_if.byte_data;
              bits_in_byte <= first_cnt;
              div          <= '0;
              // Present bit 0 straight away so it has setup before its strobe.
              cfg_data     <= byte_if.byte_data[0];
            end
          end
          S_SHIFT: begin
            if (div == DIV_LAST) begin
              div          <= '0;
              shreg        <= {1'b0, shreg[7:1]};
              bit_count    <= bit_count + 1'b1;
              bits_in_byte <= bits_in_byte - 4'd1;
`ifdef PAL_CFG_CRC_EN
              crc          <= crc8_step(crc, shreg[0]);
`endif
              // cfg_data changes only after the strobe edge, so it holds through the strobe.
              if (bits_in_byte != 4'd1) cfg_data <= shreg[1];
            end else begin
              div <= div + 1'b1;
            end
          end
`ifdef PAL_CFG_CRC_EN
          S_CHECK: begin
            if (byte_if.byte_valid && (byte_if.byte_data != crc)) crc_err <= 1'b1;
          end
`endif
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pal_cfg_loader.sv
// Self-checking bench for pal_cfg_loader (CFG_BITS=396, SHIFT_DIV=2).
// Expected chain bits are queued as bytes are handed over. A monitor pops one
// bit per cfg_shift strobe and compares it with cfg_data.
module tb_pal_cfg_loader;
  localparam int CFG_BITS  = 396;
  localparam int SHIFT_DIV = 2;
  localparam int CNT_W     = 9;
  localparam int NBYTES    = (CFG_BITS + 7) / 8;

  logic             clk = 1'b0;
  logic             res_n = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             cfg_data, cfg_shift, cfg_apply, busy, done;
  logic [CNT_W-1:0] bit_count;
`ifdef PAL_CFG_CRC_EN
  logic             crc_err;
`endif

  pal_cfg_loader_if bif();

  pal_cfg_loader #(.SHIFT_DIV(SHIFT_DIV)) dut (
    .clk       (clk),
    .res_n     (res_n),
    .start     (start),
    .abort     (abort),
    .byte_if   (bif),
    .cfg_data  (cfg_data),
    .cfg_shift (cfg_shift),
    .cfg_apply (cfg_apply),
    .busy      (busy),
    .done      (done),
    .bit_count (bit_count)
`ifdef PAL_CFG_CRC_EN
    ,
    .crc_err   (crc_err)
`endif
  );

  always #5 clk = ~clk;

  int         tests = 0;
  int         fails = 0;
  logic       exp_q[$];
  int         strobes = 0;
  int         applies = 0;
  int         pushed = 0;
  logic [7:0] model_crc = 8'h00;
  logic       prev_data = 1'b0;
  logic       prev_shift = 1'b0;
  logic       mon_exp;

  // CRC-8 model, poly 0x07, bit fed into the MSB.
  function automatic logic [7:0] crc_model(input logic [7:0] c, input logic b);
    logic [7:0] t;
    t = c ^ {b, 7'b0};
    return t[7] ? ((t << 1) ^ 8'h07) : (t << 1);
  endfunction

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (cfg_shift) begin
      strobes++;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL strobe_extra: strobe %0d with no bit expected", strobes);
      end else begin
        mon_exp = exp_q.pop_front();
        if (cfg_data !== mon_exp) begin
          fails++;
          $display("FAIL cfg_bit: strobe %0d cfg_data=%b expected %b", strobes, cfg_data, mon_exp);
        end
      end
      tests++;
      if (prev_data !== cfg_data || bif.byte_ready !== 1'b0) begin
        fails++;
        $display("FAIL shift_setup: strobe %0d prev_data=%b data=%b ready=%b expected stable, ready 0",
                 strobes, prev_data, cfg_data, bif.byte_ready);
      end
    end
    if (cfg_apply) begin
      applies++;
`ifndef PAL_CFG_CRC_EN
      tests++;
      if (prev_shift !== 1'b1) begin
        fails++;
        $display("FAIL apply_timing: previous cycle cfg_shift=%b expected 1", prev_shift);
      end
`endif
    end
    prev_data  = cfg_data;
    prev_shift = cfg_shift;
  end

  task automatic clear_model();
    exp_q.delete();
    pushed    = 0;
    model_crc = 8'h00;
    strobes   = 0;
    applies   = 0;
  endtask

  // Called in the posedge+1 phase. Returns in the posedge+1 phase after the transfer.
  task automatic send_byte(input logic [7:0] b, input int max_cyc, output bit ok);
    ok = 1'b0;
    bif.byte_data  = b;
    bif.byte_valid = 1'b1;
    for (int t = 0; t < max_cyc; t++) begin
      @(negedge clk);
      if (bif.byte_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      for (int i = 0; i < 8; i++) begin
        if (pushed < CFG_BITS) begin
          exp_q.push_back(b[i]);
          model_crc = crc_model(model_crc, b[i]);
          pushed++;
        end
      end
      @(posedge clk);
      #1;
    end
    bif.byte_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Full load: mode 0 = all 0xA5, mode 1 = random bytes. stall = idle cycles
  // in LOAD before each byte. poke_at = byte index where start is pulsed while busy.
  task automatic load_chain(input int mode, input int stall, input bit flip_crc, input int poke_at);
    bit         ok;
    logic [7:0] b;
    int         bc;
    clear_model();
    pulse_start();
    tests++;
    if ({busy, bif.byte_ready, done} !== 3'b110 || bit_count !== '0) begin
      fails++;
      $display("FAIL load_entry: busy/ready/done=%b%b%b bit_count=%0d expected 110 and 0",
               busy, bif.byte_ready, done, bit_count);
    end
    for (int i = 0; i < NBYTES; i++) begin
      if (stall > 0 && i > 0) begin
        ok = 1'b0;
        for (int t = 0; t < 100; t++) begin
          if (bif.byte_ready === 1'b1) begin
            ok = 1'b1;
            break;
          end
          @(posedge clk);
          #1;
        end
        for (int s = 0; s < stall; s++) begin
          @(posedge clk);
          #1;
          tests++;
          if (cfg_shift !== 1'b0 || bif.byte_ready !== 1'b1 || !ok) begin
            fails++;
            $display("FAIL stall_load: byte %0d shift=%b ready=%b expected 0 and 1", i, cfg_shift, bif.byte_ready);
          end
        end
      end
      if (i == poke_at) begin
        bc = int'(bit_count);
        start = 1'b1;
        for (int s = 0; s < 3; s++) begin
          @(posedge clk);
          #1;
          tests++;
          if (busy !== 1'b1 || int'(bit_count) < bc) begin
            fails++;
            $display("FAIL start_busy: busy=%b bit_count=%0d expected 1 and >= %0d", busy, bit_count, bc);
          end
        end
        start = 1'b0;
      end
      b = (mode == 0) ? 8'hA5 : 8'($urandom);
      send_byte(b, 200, ok);
      tests++;
      if (!ok) begin
        fails++;
        $display("FAIL byte_accept: byte %0d not accepted, expected accepted", i);
      end
    end
`ifdef PAL_CFG_CRC_EN
    send_byte(model_crc ^ {7'b0, flip_crc}, 200, ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL crc_accept: crc byte not accepted, expected accepted");
    end
`else
    ok = flip_crc;
`endif
    ok = 1'b0;
    for (int t = 0; t < 300; t++) begin
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL done_timeout: done=%b expected 1 within 300 cycles", done);
    end
  endtask

  task automatic test_reset();
    res_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({bif.byte_ready, cfg_data, cfg_shift, cfg_apply, busy, done} !== 6'b0 || bit_count !== '0) begin
      fails++;
      $display("FAIL reset_values: outputs=%b bit_count=%0d expected 000000 and 0",
               {bif.byte_ready, cfg_data, cfg_shift, cfg_apply, busy, done}, bit_count);
    end
    res_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (busy !== 1'b0 || bif.byte_ready !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL idle_after_reset: busy=%b ready=%b done=%b expected 0 0 0", busy, bif.byte_ready, done);
    end
  endtask

  task automatic check_complete(input string name, input int exp_applies);
    tests++;
    if (strobes !== CFG_BITS || applies !== exp_applies || bit_count !== CNT_W'(CFG_BITS) ||
        done !== 1'b1 || busy !== 1'b0 || bif.byte_ready !== 1'b0 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s: strobes=%0d applies=%0d bit_count=%0d done=%b busy=%b ready=%b left=%0d expected %0d %0d %0d 1 0 0 0",
               name, strobes, applies, bit_count, done, busy, bif.byte_ready, exp_q.size(),
               CFG_BITS, exp_applies, CFG_BITS);
    end
  endtask

  task automatic test_stream();
    load_chain(0, 0, 1'b0, -1);
    check_complete("stream_a5", 1);
  endtask

  task automatic test_host_stall();
    load_chain(0, 10, 1'b0, -1);
    check_complete("stream_stall", 1);
  endtask

  task automatic test_abort();
    bit ok;
    clear_model();
    pulse_start();
    for (int i = 0; i < 13; i++) send_byte(8'($urandom), 200, ok);
    ok = 1'b0;
    for (int t = 0; t < 50; t++) begin
      if (strobes == 100) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    tests++;
    if (!ok || busy !== 1'b0 || done !== 1'b0 || bif.byte_ready !== 1'b0 || bit_count !== 9'd100) begin
      fails++;
      $display("FAIL abort_state: reached=%b busy=%b done=%b ready=%b bit_count=%0d expected 1 0 0 0 100",
               ok, busy, done, bif.byte_ready, bit_count);
    end
    repeat (6) @(posedge clk);
    #1;
    tests++;
    if (strobes !== 100 || applies !== 0 || bit_count !== 9'd100) begin
      fails++;
      $display("FAIL abort_quiet: strobes=%0d applies=%0d bit_count=%0d expected 100 0 100", strobes, applies, bit_count);
    end
    load_chain(1, 0, 1'b0, -1);
    check_complete("reload_after_abort", 1);
  endtask

  task automatic test_reset_mid_shift();
    bit ok;
    clear_model();
    pulse_start();
    for (int i = 0; i < 3; i++) send_byte(8'hA5, 200, ok);
    @(posedge clk);
    #2;
    res_n = 1'b0;
    #1;
    tests++;
    if ({bif.byte_ready, cfg_data, cfg_shift, cfg_apply, busy, done} !== 6'b0 || bit_count !== '0) begin
      fails++;
      $display("FAIL async_reset: outputs=%b bit_count=%0d expected 000000 and 0",
               {bif.byte_ready, cfg_data, cfg_shift, cfg_apply, busy, done}, bit_count);
    end
    @(posedge clk);
    #1;
    res_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (applies !== 0 || busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL reset_no_apply: applies=%0d busy=%b done=%b expected 0 0 0", applies, busy, done);
    end
    exp_q.delete();
  endtask

  task automatic test_ignored();
    bit ok;
    load_chain(1, 0, 1'b0, 20);
    check_complete("start_while_busy", 1);
    send_byte(8'hFF, 20, ok);
    repeat (4) @(posedge clk);
    #1;
    tests++;
    if (ok || bif.byte_ready !== 1'b0 || strobes !== CFG_BITS || done !== 1'b1 || applies !== 1) begin
      fails++;
      $display("FAIL bytes_in_done: accepted=%b ready=%b strobes=%0d done=%b applies=%0d expected 0 0 %0d 1 1",
               ok, bif.byte_ready, strobes, done, applies, CFG_BITS);
    end
  endtask

`ifdef PAL_CFG_CRC_EN
  task automatic test_crc();
    load_chain(1, 0, 1'b0, -1);
    check_complete("crc_good", 1);
    tests++;
    if (crc_err !== 1'b0) begin
      fails++;
      $display("FAIL crc_good_err: crc_err=%b expected 0", crc_err);
    end
    load_chain(1, 0, 1'b1, -1);
    check_complete("crc_bad", 0);
    tests++;
    if (crc_err !== 1'b1) begin
      fails++;
      $display("FAIL crc_bad_err: crc_err=%b expected 1", crc_err);
    end
  endtask
`endif

  initial begin
    bif.byte_data  = 8'h00;
    bif.byte_valid = 1'b0;
    test_reset();
    test_stream();
    test_host_stall();
    test_abort();
    test_reset_mid_shift();
    test_ignored();
`ifdef PAL_CFG_CRC_EN
    test_crc();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, expected finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
